mii_tx_framer: RTL and testbench

- Transmit-side MII framer. Sits after append_crc on the TX path.
- Takes one frame on a byte-wide AXI-stream; the frame already carries its FCS.
- Emits preamble, SFD and frame data as MII nibbles, low nibble first, then enforces the inter-frame gap.
- Mirror of the RX deframer / remove_crc path; runs on the MII TX clock, one nibble per cycle.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/mii_tx_framer.sv | 217 +++++++++++++++++++++
 tb/tb_mii_tx_framer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/MII definitions for the TX path: wire constants and the
// MII TX framer state encoding.
package eth_pkg;

  localparam logic [3:0] MII_PREAMBLE_NIBBLE   = 4'h5;
  localparam logic [7:0] ETH_SFD               = 8'hD5;
  localparam int         ETH_DEFAULT_IFG_BYTES = 12;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DATA_LO  = 3'd2,
    S_DATA_HI  = 3'd3,
    S_UNDERRUN = 3'd4,
    S_DRAIN    = 3'd5,
    S_IFG      = 3'd6
  } mii_tx_state_t;

  // Larger of two integers, used to size the shared nibble counter.
  function automatic int eth_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mii_tx_framer.sv
// MII transmit framer: byte-wide AXI-stream frame (FCS already appended) in,
// preamble + SFD + data nibbles (low nibble first) out, followed by the
// inter-frame gap. An upstream stall mid-frame is signalled with a single
// tx_er nibble, after which the rest of the frame is discarded.
// Optional build macro MII_TX_FRAMER_STATS_EN adds saturating frame_count
// and underrun_count outputs.
module mii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = ETH_DEFAULT_IFG_BYTES
) (
  input  logic        clock,
  input  logic        aresetn,
  input  logic [7:0]  saxis_tdata,
  input  logic        saxis_tvalid,
  output logic        saxis_tready,
  input  logic        saxis_tuser,
  input  logic        saxis_tlast,
  output logic [3:0]  mii_txd,
  output logic        mii_tx_en,
  output logic        mii_tx_er
`ifdef MII_TX_FRAMER_STATS_EN
  ,
  output logic [31:0] frame_count,
  output logic [15:0] underrun_count
`endif
);

  localparam int CNT_W = $clog2(2 * eth_max(PREAMBLE_BYTES + 1, IFG_BYTES) + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(2 * PREAMBLE_BYTES + 1);
  // The IDLE cycle that samples tvalid is the last cycle of the gap, so the
  // IFG state itself holds one cycle less than the full gap.
  localparam logic [CNT_W-1:0] IFG_LOAD = CNT_W'(2 * IFG_BYTES - 2);

  mii_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [3:0]       txd_q, txd_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic             tready_q, tready_d;
  logic             hs_s;

  assign hs_s = saxis_tvalid & tready_q;

  // Next-state, counter and hold-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (saxis_tvalid) begin
          state_d = S_PREAMBLE;
          cnt_d   = PRE_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREAMBLE: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (hs_s) begin
          hold_d  = saxis_tdata;
          last_d  = saxis_tlast;
          err_d   = saxis_tuser;
          state_d = S_DATA_LO;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_UNDERRUN;
          cnt_d   = CNT_ZERO;
        end
      end
      S_DATA_LO: begin
        state_d = S_DATA_HI;
      end
      S_DATA_HI: begin
        if (last_q) begin
          state_d = S_IFG;
          cnt_d   = IFG_LOAD;
        end else if (hs_s) begin
          hold_d  = saxis_tdata;
          last_d  = saxis_tlast;
          err_d   = saxis_tuser;
          state_d = S_DATA_LO;
        end else begin
          state_d = S_UNDERRUN;
        end
      end
      S_UNDERRUN: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (hs_s && saxis_tlast) begin
          state_d = S_IFG;
          cnt_d   = IFG_LOAD;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_IFG: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    txd_d    = 4'h0;
    tx_en_d  = 1'b0;
    tx_er_d  = 1'b0;
    tready_d = 1'b0;
    case (state_d)
      S_PREAMBLE: begin
        tx_en_d  = 1'b1;
        tready_d = (cnt_d == CNT_ZERO);
        if (cnt_d == CNT_ZERO) begin
          txd_d = ETH_SFD[7:4];
        end else if (cnt_d == CNT_ONE) begin
          txd_d = ETH_SFD[3:0];
        end else begin
          txd_d = MII_PREAMBLE_NIBBLE;
        end
      end
      S_DATA_LO: begin
        tx_en_d = 1'b1;
        txd_d   = hold_d[3:0];
        tx_er_d = last_d & err_d;
      end
      S_DATA_HI: begin
        tx_en_d  = 1'b1;
        txd_d    = hold_d[7:4];
        tx_er_d  = last_d & err_d;
        tready_d = ~last_d;
      end
      S_UNDERRUN: begin
        tx_en_d = 1'b1;
        tx_er_d = 1'b1;
      end
      S_DRAIN: begin
        tready_d = 1'b1;
      end
      default: begin
        txd_d = 4'h0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      hold_q   <= 8'h00;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      txd_q    <= 4'h0;
      tx_en_q  <= 1'b0;
      tx_er_q  <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      err_q    <= err_d;
      txd_q    <= txd_d;
      tx_en_q  <= tx_en_d;
      tx_er_q  <= tx_er_d;
      tready_q <= tready_d;
    end
  end

  assign mii_txd      = txd_q;
  assign mii_tx_en    = tx_en_q;
  assign mii_tx_er    = tx_er_q;
  assign saxis_tready = tready_q;

`ifdef MII_TX_FRAMER_STATS_EN
  logic [31:0] frame_count_q;
  logic [15:0] underrun_count_q;

  // Saturating counts of completed frames and underrun events.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      frame_count_q    <= 32'd0;
      underrun_count_q <= 16'd0;
    end else begin
      if ((state_q == S_DATA_HI) && (state_d == S_IFG) && (frame_count_q != 32'hFFFF_FFFF)) begin
        frame_count_q <= frame_count_q + 32'd1;
      end
      if ((state_d == S_UNDERRUN) && (state_q != S_UNDERRUN) && (underrun_count_q != 16'hFFFF)) begin
        underrun_count_q <= underrun_count_q + 16'd1;
      end
    end
  end

  assign frame_count    = frame_count_q;
  assign underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench for mii_tx_framer: drives frames on the AXI-stream side,
// logs the MII side every cycle and checks the log against frames rebuilt
// from the stimulus.
module tb_mii_tx_framer;

  localparam int PRE  = 7;
  localparam int IFG  = 12;
  localparam int NPRE = 2 * PRE + 2;
  localparam int GAP  = 2 * IFG;
  localparam int LOGN = 4096;

  logic       clock = 1'b0;
  logic       aresetn;
  logic [7:0] saxis_tdata;
  logic       saxis_tvalid;
  logic       saxis_tready;
  logic       saxis_tuser;
  logic       saxis_tlast;
  logic [3:0] mii_txd;
  logic       mii_tx_en;
  logic       mii_tx_er;
`ifdef MII_TX_FRAMER_STATS_EN
  logic [31:0] frame_count;
  logic [15:0] underrun_count;
`endif

  mii_tx_framer #(.PREAMBLE_BYTES(PRE), .IFG_BYTES(IFG)) dut (
    .clock        (clock),
    .aresetn      (aresetn),
    .saxis_tdata  (saxis_tdata),
    .saxis_tvalid (saxis_tvalid),
    .saxis_tready (saxis_tready),
    .saxis_tuser  (saxis_tuser),
    .saxis_tlast  (saxis_tlast),
    .mii_txd      (mii_txd),
    .mii_tx_en    (mii_tx_en),
    .mii_tx_er    (mii_tx_er)
`ifdef MII_TX_FRAMER_STATS_EN
    ,
    .frame_count    (frame_count),
    .underrun_count (underrun_count)
`endif
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Source: {tuser, tlast, tdata} beats, popped on handshake.
  logic [9:0] src_q[$];
  int  pops      = 0;
  int  stall_at  = -1;
  int  stall_cnt = 0;
  bit  hs_prev   = 1'b0;

  initial begin
    saxis_tvalid = 1'b0;
    saxis_tdata  = 8'h00;
    saxis_tlast  = 1'b0;
    saxis_tuser  = 1'b0;
    forever begin
      @(negedge clock);
      if (hs_prev && src_q.size() > 0) begin
        void'(src_q.pop_front());
        pops++;
        if (pops == stall_at) stall_cnt = 3;
      end
      if (stall_cnt > 0) begin
        stall_cnt--;
        saxis_tvalid = 1'b0;
      end else if (src_q.size() > 0) begin
        saxis_tvalid = 1'b1;
        {saxis_tuser, saxis_tlast, saxis_tdata} = src_q[0];
      end else begin
        saxis_tvalid = 1'b0;
      end
      hs_prev = saxis_tvalid && saxis_tready;
    end
  end

  // Monitor: one log entry per cycle, sampled mid-cycle.
  logic [3:0] log_txd[LOGN];
  bit         log_en[LOGN];
  bit         log_er[LOGN];
  bit         log_rdy[LOGN];
  int         log_n = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (log_n < LOGN) begin
        log_txd[log_n] = mii_txd;
        log_en[log_n]  = mii_tx_en;
        log_er[log_n]  = mii_tx_er;
        log_rdy[log_n] = saxis_tready;
        log_n++;
      end
    end
  end

  // Frame records for the model.
  logic [7:0] tmp[$];
  int         fr_len[$];
  bit         fr_user[$];
  logic [7:0] fr_bytes[$];

  task automatic clear_frames();
    fr_len.delete();
    fr_user.delete();
    fr_bytes.delete();
    log_n = 0;
  endtask

  task automatic push_frame(input bit user);
    bit is_last;
    fr_len.push_back(tmp.size());
    fr_user.push_back(user);
    foreach (tmp[i]) begin
      is_last = (i == tmp.size() - 1);
      fr_bytes.push_back(tmp[i]);
      src_q.push_back({user && is_last, is_last, tmp[i]});
    end
    tmp.delete();
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 40 && n < budget) begin
      @(negedge clock);
      n++;
      if (src_q.size() == 0 && !mii_tx_en) quiet++;
      else quiet = 0;
    end
    check({tag, "_done"}, (quiet >= 40), 1);
  endtask

  function automatic int find_burst(input int from);
    for (int i = from; i < log_n; i++) if (log_en[i]) return i;
    return -1;
  endfunction

  function automatic int burst_len(input int s);
    int l = 0;
    while (s + l < log_n && log_en[s + l]) l++;
    return l;
  endfunction

  // Expected nibble / error for position i of a burst carrying frame f.
  task automatic exp_nibble(input int i, input int f, input int boff,
                            output logic [3:0] en, output bit ee, output bit ok);
    int j;
    logic [7:0] b;
    en = 4'h5; ee = 1'b0; ok = 1'b1;
    if (i == NPRE - 1) en = 4'hD;
    else if (i >= NPRE) begin
      j = (i - NPRE) / 2;
      if (j < fr_len[f]) begin
        b  = fr_bytes[boff + j];
        en = (((i - NPRE) % 2) == 0) ? b[3:0] : b[7:4];
        ee = fr_user[f] && (j == fr_len[f] - 1);
      end else begin
        ok = 1'b0;
      end
    end
  endtask

  // Check every recorded frame against the log: length, nibbles, tx_er,
  // tready count, gap between frames and silence afterwards.
  task automatic analyze_frames(input string tag);
    int pos = 0;
    int prev_end = -1;
    int boff = 0;
    int s, l, n, nib_bad, er_bad, rdy_cnt;
    logic [3:0] en;
    bit ee, ok;
    for (int f = 0; f < fr_len.size(); f++) begin
      s = find_burst(pos);
      if (s < 0) begin
        check({tag, "_burst_found"}, 0, 1);
        return;
      end
      n = fr_len[f];
      l = burst_len(s);
      check({tag, "_len"}, l, NPRE + 2 * n);
      nib_bad = 0; er_bad = 0; rdy_cnt = 0;
      for (int i = 0; i < l; i++) begin
        exp_nibble(i, f, boff, en, ee, ok);
        if (!ok || log_txd[s + i] !== en) nib_bad++;
        if (log_er[s + i] !== ee) er_bad++;
        if (log_rdy[s + i]) rdy_cnt++;
      end
      check({tag, "_nibbles_bad"}, nib_bad, 0);
      check({tag, "_tx_er_bad"}, er_bad, 0);
      check({tag, "_tready_beats"}, rdy_cnt, n);
      if (f > 0) check({tag, "_gap"}, s - prev_end, GAP);
      prev_end = s + l;
      pos = s + l;
      boff += n;
    end
    check({tag, "_no_extra_burst"}, find_burst(pos), 32'hFFFF_FFFF);
    check({tag, "_tail_quiet"}, (log_n - prev_end) >= GAP, 1);
  endtask

  int s, l, nxt, r, er_cnt, nib_bad, nwait;
  logic [3:0] en;
  bit ee, ok;

  initial begin
    aresetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_txd", mii_txd, 4'h0);
    check("rst_tx_en", mii_tx_en, 1'b0);
    check("rst_tx_er", mii_tx_er, 1'b0);
    check("rst_tready", saxis_tready, 1'b0);
`ifdef MII_TX_FRAMER_STATS_EN
    check("rst_frame_count", frame_count, 32'd0);
    check("rst_underrun_count", underrun_count, 16'd0);
`endif
    aresetn = 1'b1;
    repeat (2) @(negedge clock);

    // Two-byte frame: 15x5, D, 2, 1, 4, 3.
    clear_frames();
    tmp = '{8'h12, 8'h34};
    push_frame(1'b0);
    wait_quiet("two_byte", 500);
    analyze_frames("two_byte");

    // Three-byte frame with bad last beat.
    clear_frames();
    tmp = '{8'hA1, 8'hB2, 8'hC3};
    push_frame(1'b1);
    wait_quiet("bad_last", 500);
    analyze_frames("bad_last");

    // Single-byte frame.
    clear_frames();
    tmp = '{8'h9E};
    push_frame(1'b0);
    wait_quiet("one_byte", 500);
    analyze_frames("one_byte");

    // Back-to-back frames with tvalid held high.
    clear_frames();
    tmp = '{8'h01, 8'h23, 8'h45, 8'h67};
    push_frame(1'b0);
    tmp = '{8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hF0};
    push_frame(1'b0);
    wait_quiet("b2b", 1000);
    analyze_frames("b2b");

    // Underrun after byte 2 of a 10-byte frame, then a short frame.
    clear_frames();
    pops = 0;
    stall_at = 3;
    for (int k = 0; k < 10; k++) tmp.push_back(8'h10 + 8'(k));
    push_frame(1'b0);
    tmp = '{8'h77};
    push_frame(1'b0);
    wait_quiet("underrun", 1000);
    stall_at = -1;
    s = find_burst(0);
    l = (s >= 0) ? burst_len(s) : 0;
    check("underrun_len", l, NPRE + 6 + 1);
    check("underrun_last_txd", log_txd[s + l - 1], 4'h0);
    check("underrun_last_er", log_er[s + l - 1], 1'b1);
    er_cnt = 0; nib_bad = 0;
    for (int i = 0; i < l; i++) begin
      if (log_er[s + i]) er_cnt++;
      if (i < l - 1) begin
        exp_nibble(i, 0, 0, en, ee, ok);
        if (!ok || log_txd[s + i] !== en) nib_bad++;
      end
    end
    check("underrun_er_count", er_cnt, 1);
    check("underrun_nibbles_bad", nib_bad, 0);
    check("underrun_bytes_consumed", pops, 11);
    nxt = find_burst(s + l);
    r = -1;
    for (int i = s + l; i < nxt; i++) if (log_rdy[i]) r = i;
    check("underrun_ifg", nxt - r - 1, GAP);
    check("underrun_next_len", (nxt >= 0) ? burst_len(nxt) : 0, NPRE + 2);
`ifdef MII_TX_FRAMER_STATS_EN
    check("underrun_count", underrun_count, 16'd1);
    check("frame_count", frame_count, 32'd6);
`endif

    // Reset for one cycle in the middle of data.
    clear_frames();
    for (int k = 0; k < 8; k++) tmp.push_back(8'hC0 + 8'(k));
    push_frame(1'b0);
    nwait = 0;
    while (!mii_tx_en && nwait < 50) begin
      @(negedge clock);
      nwait++;
    end
    check("rst_mid_started", mii_tx_en, 1'b1);
    repeat (NPRE + 4) @(negedge clock);
    aresetn = 1'b0;
    src_q.delete();
    @(negedge clock);
    check("rst_mid_tx_en", mii_tx_en, 1'b0);
    check("rst_mid_tready", saxis_tready, 1'b0);
    aresetn = 1'b1;
    wait_quiet("rst_mid", 500);
    clear_frames();
    tmp = '{8'h5A};
    push_frame(1'b0);
    wait_quiet("rst_restart", 500);
    analyze_frames("rst_restart");

    // Random back-to-back frames of 1..24 bytes.
    clear_frames();
    for (int f = 0; f < 20; f++) begin
      int n = $urandom_range(24, 1);
      for (int k = 0; k < n; k++) tmp.push_back(8'($urandom));
      push_frame(1'($urandom_range(1, 0)));
    end
    wait_quiet("random", 5000);
    analyze_frames("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
